// File: rtl/ghost_mode_ctrl_if.sv
// Ghost mode bus: event pulses from the game core into the mode sequencer,
// and the mode/strobe outputs fanned out to every ghost movement block.
// Signalling: there is no valid/ready handshake on this bus. pelletEaten and
// pacmanDied are single-cycle event pulses sampled on every rising clk edge;
// a pulse held high for N cycles counts as N events. All outputs are
// registered levels, except frameTick and reverseDir, which are one-cycle
// strobes.
interface ghost_mode_ctrl_if;
    logic       pelletEaten;
    logic       pacmanDied;
    logic       frameTick;
    logic       isScatter;
    logic       isChase;
    logic       isFrightened;
    logic       frightFlash;
    logic       reverseDir;
    logic [2:0] phaseIdx;

    // Game core side: raises events, observes ghost mode.
    modport master (
        output pelletEaten,
        output pacmanDied,
        input  frameTick,
        input  isScatter,
        input  isChase,
        input  isFrightened,
        input  frightFlash,
        input  reverseDir,
        input  phaseIdx
    );

    // Mode sequencer side.
    modport slave (
        input  pelletEaten,
        input  pacmanDied,
        output frameTick,
        output isScatter,
        output isChase,
        output isFrightened,
        output frightFlash,
        output reverseDir,
        output phaseIdx
    );
endinterface

// File: rtl/ghost_mode_ctrl.sv
// Global ghost behaviour sequencer: frame tick generator, spawn delay,
// scatter/chase phase schedule and frightened override with reversal strobes.
module ghost_mode_ctrl #(
    parameter int TICK_DIV           = 416_667,
    parameter int START_DELAY_FRAMES = 300,
    parameter int SCAT1              = 420,
    parameter int CHASE1             = 1200,
    parameter int SCAT2              = 420,
    parameter int CHASE2             = 1200,
    parameter int SCAT3              = 300,
    parameter int CHASE3             = 1200,
    parameter int SCAT4              = 300,
    parameter int FRIGHT_FRAMES      = 360,
    parameter int FLASH_FRAMES       = 120
) (
    input  logic               clk,
    input  logic               reset,
    ghost_mode_ctrl_if.slave   bus,
    output logic [1:0]         dbgState
);

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        RUN    = 2'd1,
        FRIGHT = 2'd2
    } state_t;

    localparam int                TICK_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [8:0]        DELAY_LAST  = 9'(START_DELAY_FRAMES - 1);
    localparam logic [8:0]        FRIGHT_LAST = 9'(FRIGHT_FRAMES - 1);
    localparam logic [8:0]        FLASH_START = 9'(FRIGHT_FRAMES - FLASH_FRAMES);
    localparam bit                FRIGHT_EN   = (FRIGHT_FRAMES > 0);

    // Last count value of each scheduled phase; phase 7 never expires.
    function automatic logic [11:0] phaseLast(input logic [2:0] p);
        case (p)
            3'd0:    phaseLast = 12'(SCAT1 - 1);
            3'd1:    phaseLast = 12'(CHASE1 - 1);
            3'd2:    phaseLast = 12'(SCAT2 - 1);
            3'd3:    phaseLast = 12'(CHASE2 - 1);
            3'd4:    phaseLast = 12'(SCAT3 - 1);
            3'd5:    phaseLast = 12'(CHASE3 - 1);
            3'd6:    phaseLast = 12'(SCAT4 - 1);
            default: phaseLast = 12'hFFF;
        endcase
    endfunction

    logic [TICK_W-1:0] tickCnt;
    logic              frameTickQ;

    state_t      state,      stateN;
    logic [8:0]  delayCnt,   delayCntN;
    logic [11:0] phaseCnt,   phaseCntN;
    logic [8:0]  frightCnt,  frightCntN;
    logic [2:0]  phaseIdx,   phaseIdxN;

    logic scatterQ, chaseQ, frightQ, flashQ, reverseQ;
    logic scatterN, chaseN, frightN, flashN, reverseN;

    // Free-running frame divider; the tick strobe is registered one cycle after the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            tickCnt    <= '0;
            frameTickQ <= 1'b0;
        end else begin
            if (tickCnt == TICK_LAST) begin
                tickCnt <= '0;
            end else begin
                tickCnt <= tickCnt + 1'b1;
            end
            frameTickQ <= (tickCnt == TICK_LAST);
        end
    end

    // Next-state, counter and output decode; death beats pellet beats tick expiry.
    always_comb begin
        stateN     = state;
        delayCntN  = delayCnt;
        phaseCntN  = phaseCnt;
        frightCntN = frightCnt;
        phaseIdxN  = phaseIdx;
        reverseN   = 1'b0;

        if (bus.pacmanDied) begin
            // Phase position survives a lost life; only the spawn delay restarts.
            stateN     = WAIT;
            delayCntN  = '0;
            frightCntN = '0;
        end else begin
            case (state)
                WAIT: begin
                    if (frameTickQ) begin
                        if (delayCnt == DELAY_LAST) begin
                            stateN    = RUN;
                            delayCntN = '0;
                        end else begin
                            delayCntN = delayCnt + 9'd1;
                        end
                    end
                end
                RUN: begin
                    if (frameTickQ && (phaseIdx != 3'd7)) begin
                        if (phaseCnt == phaseLast(phaseIdx)) begin
                            phaseIdxN = phaseIdx + 3'd1;
                            phaseCntN = '0;
                            reverseN  = 1'b1;
                        end else begin
                            phaseCntN = phaseCnt + 12'd1;
                        end
                    end
                    // A pellet on a phase-expiry cycle still lets the phase advance;
                    // both events share the single reversal strobe.
                    if (bus.pelletEaten && FRIGHT_EN) begin
                        stateN     = FRIGHT;
                        frightCntN = '0;
                        reverseN   = 1'b1;
                    end
                end
                FRIGHT: begin
                    if (bus.pelletEaten) begin
                        frightCntN = '0;
                    end else if (frameTickQ) begin
                        if (frightCnt == FRIGHT_LAST) begin
                            stateN = RUN;
                        end else begin
                            frightCntN = frightCnt + 9'd1;
                        end
                    end
                end
                default: begin
                    stateN = WAIT;
                end
            endcase
        end

        scatterN = (stateN == RUN) && !phaseIdxN[0] && (phaseIdxN != 3'd7);
        chaseN   = (stateN == RUN) && (phaseIdxN[0] || (phaseIdxN == 3'd7));
        frightN  = (stateN == FRIGHT);
        flashN   = (stateN == FRIGHT) && (frightCntN >= FLASH_START);
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT;
            delayCnt  <= '0;
            phaseCnt  <= '0;
            frightCnt <= '0;
            phaseIdx  <= '0;
        end else begin
            state     <= stateN;
            delayCnt  <= delayCntN;
            phaseCnt  <= phaseCntN;
            frightCnt <= frightCntN;
            phaseIdx  <= phaseIdxN;
        end
    end

    // Registered mode outputs so they appear together with reverseDir.
    always_ff @(posedge clk) begin
        if (reset) begin
            scatterQ <= 1'b0;
            chaseQ   <= 1'b0;
            frightQ  <= 1'b0;
            flashQ   <= 1'b0;
            reverseQ <= 1'b0;
        end else begin
            scatterQ <= scatterN;
            chaseQ   <= chaseN;
            frightQ  <= frightN;
            flashQ   <= flashN;
            reverseQ <= reverseN;
        end
    end

    assign bus.frameTick    = frameTickQ;
    assign bus.isScatter    = scatterQ;
    assign bus.isChase      = chaseQ;
    assign bus.isFrightened = frightQ;
    assign bus.frightFlash  = flashQ;
    assign bus.reverseDir   = reverseQ;
    assign bus.phaseIdx     = phaseIdx;
    assign dbgState         = state;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Bench for ghost_mode_ctrl with small timing parameters.
module tb_ghost_mode_ctrl;

    localparam int TD = 4;
    localparam int SD = 2;
    localparam int FF = 4;
    localparam int FL = 2;

    int dur [7] = '{3, 5, 3, 5, 3, 5, 3};

    logic       clk;
    logic       reset;
    logic [1:0] dbg;
    int         checks = 0;
    int         errors = 0;

    ghost_mode_ctrl_if ifc();

    ghost_mode_ctrl #(
        .TICK_DIV(TD), .START_DELAY_FRAMES(SD),
        .SCAT1(3), .CHASE1(5), .SCAT2(3), .CHASE2(5), .SCAT3(3), .CHASE3(5), .SCAT4(3),
        .FRIGHT_FRAMES(FF), .FLASH_FRAMES(FL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc),
        .dbgState(dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame-level game rules tracked with plain integers.
    // m_mode: 0 waiting to spawn, 1 running the schedule, 2 frightened.
    int m_tc, m_mode, m_ph, m_pc, m_dc, m_fc;
    bit e_tick, e_rev;

    always @(posedge clk) begin : model_blk
        bit t;
        if (reset) begin
            m_tc = 0; e_tick = 0; e_rev = 0;
            m_mode = 0; m_ph = 0; m_pc = 0; m_dc = 0; m_fc = 0;
        end else begin
            t = e_tick;
            e_rev = 0;
            if (ifc.pacmanDied) begin
                m_mode = 0; m_dc = 0; m_fc = 0;
            end else if (m_mode == 0) begin
                if (t) begin
                    m_dc++;
                    if (m_dc == SD) begin m_mode = 1; m_dc = 0; end
                end
            end else if (m_mode == 1) begin
                if (t && m_ph < 7) begin
                    m_pc++;
                    if (m_pc == dur[m_ph]) begin m_ph++; m_pc = 0; e_rev = 1; end
                end
                if (ifc.pelletEaten && FF > 0) begin m_mode = 2; m_fc = 0; e_rev = 1; end
            end else begin
                if (ifc.pelletEaten) m_fc = 0;
                else if (t) begin
                    if (m_fc + 1 == FF) m_mode = 1;
                    else m_fc++;
                end
            end
            m_tc++;
            e_tick = ((m_tc % TD) == 0);
        end
    end

    logic [8:0] e_vec, d_vec;
    always_comb begin
        e_vec = {e_tick,
                 (m_mode == 1) && (m_ph % 2 == 0) && (m_ph < 7),
                 (m_mode == 1) && (m_ph % 2 == 1),
                 (m_mode == 2),
                 (m_mode == 2) && (m_fc >= FF - FL),
                 e_rev,
                 3'(m_ph)};
        d_vec = {ifc.frameTick, ifc.isScatter, ifc.isChase, ifc.isFrightened,
                 ifc.frightFlash, ifc.reverseDir, ifc.phaseIdx};
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset(input string tag);
        reset = 1'b1;
        ifc.pelletEaten = 1'b1;
        ifc.pacmanDied  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (d_vec !== 9'd0) begin
                errors++;
                $display("FAIL %s_outputs: got %b want %b", tag, d_vec, 9'd0);
            end
            checks++;
            if (dbg !== 2'd0) begin
                errors++;
                $display("FAIL %s_state: got %0d want 0", tag, dbg);
            end
        end
        reset = 1'b0;
        ifc.pelletEaten = 1'b0;
    endtask

    task automatic test_startup();
        int n = 0, ticks = 0, revs = 0;
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc(); n++;
            checks++;
            if (d_vec !== e_vec) begin
                errors++;
                $display("FAIL startup_model: cycle %0d got %b want %b", n, d_vec, e_vec);
            end
            if (ifc.frameTick) ticks++;
            if (ifc.reverseDir) revs++;
            if (ifc.isScatter) ok = 1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL startup_timeout: no isScatter within 40 cycles"); end
        checks++;
        if (n != 2 * TD + 1) begin errors++; $display("FAIL startup_latency: got %0d cycles want %0d", n, 2 * TD + 1); end
        checks++;
        if (ticks != SD) begin errors++; $display("FAIL startup_ticks: got %0d want %0d", ticks, SD); end
        checks++;
        if (revs != 0) begin errors++; $display("FAIL startup_reverse: got %0d want 0", revs); end
        checks++;
        if (ifc.phaseIdx !== 3'd0) begin errors++; $display("FAIL startup_phase: got %0d want 0", ifc.phaseIdx); end
    endtask

    task automatic test_schedule();
        int tks = 0, seg = 0, revs = 0, last_tick = -1, n = 0, after = 0;
        for (int i = 0; i < 400 && after < 40; i++) begin
            cyc(); n++;
            checks++;
            if (d_vec !== e_vec) begin
                errors++;
                $display("FAIL schedule_model: cycle %0d got %b want %b", n, d_vec, e_vec);
            end
            if (ifc.frameTick) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (n - last_tick != TD) begin
                        errors++;
                        $display("FAIL tick_period: got %0d want %0d", n - last_tick, TD);
                    end
                end
                last_tick = n;
                tks++;
            end
            if (ifc.reverseDir) begin
                if (seg < 7) begin
                    checks++;
                    if (tks != dur[seg]) begin
                        errors++;
                        $display("FAIL phase_len_%0d: got %0d ticks want %0d", seg, tks, dur[seg]);
                    end
                end
                seg++; tks = 0; revs++;
            end
            if (ifc.phaseIdx == 3'd7) after++;
        end
        checks++;
        if (after < 40) begin errors++; $display("FAIL schedule_timeout: phase 7 held %0d cycles want 40", after); end
        checks++;
        if (revs != 7) begin errors++; $display("FAIL schedule_reverses: got %0d want 7", revs); end
        checks++;
        if (ifc.isChase !== 1'b1 || ifc.phaseIdx !== 3'd7) begin
            errors++;
            $display("FAIL schedule_final: isChase %b phase %0d want 1 and 7", ifc.isChase, ifc.phaseIdx);
        end
    endtask

    task automatic test_fright();
        int tk = 0, revs = 0, flash_at = -1, guard = 0;
        test_reset("fright_rst");
        // reach phase 1
        for (int i = 0; i < 100 && ifc.phaseIdx != 3'd1; i++) begin
            cyc();
            checks++;
            if (d_vec !== e_vec) begin errors++; $display("FAIL fright_pre_model: got %b want %b", d_vec, e_vec); end
        end
        // two ticks into phase 1
        for (int i = 0; i < 20 && tk < 2; i++) begin
            cyc();
            if (ifc.frameTick) tk++;
        end
        cyc();
        ifc.pelletEaten = 1'b1;
        cyc();
        ifc.pelletEaten = 1'b0;
        checks++;
        if ({ifc.isFrightened, ifc.reverseDir, ifc.isChase, ifc.phaseIdx} !== {1'b1, 1'b1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL fright_entry: fr %b rev %b chase %b phase %0d want 1 1 0 1",
                     ifc.isFrightened, ifc.reverseDir, ifc.isChase, ifc.phaseIdx);
        end
        tk = 0;
        while (ifc.isFrightened && guard < 40) begin
            cyc(); guard++;
            checks++;
            if (d_vec !== e_vec) begin errors++; $display("FAIL fright_model: got %b want %b", d_vec, e_vec); end
            if (ifc.reverseDir) revs++;
            if (ifc.frightFlash && flash_at < 0) flash_at = tk;
            if (ifc.frameTick && ifc.isFrightened) tk++;
        end
        checks++;
        if (tk != FF) begin errors++; $display("FAIL fright_len: got %0d ticks want %0d", tk, FF); end
        checks++;
        if (flash_at != FF - FL) begin errors++; $display("FAIL flash_start: got %0d want %0d", flash_at, FF - FL); end
        checks++;
        if (revs != 0) begin errors++; $display("FAIL fright_exit_reverse: got %0d want 0", revs); end
        checks++;
        if (ifc.isChase !== 1'b1 || ifc.phaseIdx !== 3'd1) begin
            errors++;
            $display("FAIL fright_resume: chase %b phase %0d want 1 1", ifc.isChase, ifc.phaseIdx);
        end
        // phase 1 resumes at count 2: three more ticks to expiry
        tk = 0; guard = 0;
        while (!ifc.reverseDir && guard < 40) begin
            cyc(); guard++;
            if (ifc.frameTick) tk++;
        end
        checks++;
        if (tk != 3 || ifc.phaseIdx !== 3'd2) begin
            errors++;
            $display("FAIL fright_phase_hold: got %0d ticks phase %0d want 3 ticks phase 2", tk, ifc.phaseIdx);
        end
    endtask

    task automatic test_fright_extend();
        int tk = 0, tk2 = 0, revs = 0, guard = 0;
        bit ext = 0;
        cyc();
        ifc.pelletEaten = 1'b1;
        cyc();
        ifc.pelletEaten = 1'b0;
        checks++;
        if (ifc.isFrightened !== 1'b1 || ifc.reverseDir !== 1'b1) begin
            errors++;
            $display("FAIL extend_entry: fr %b rev %b want 1 1", ifc.isFrightened, ifc.reverseDir);
        end
        while (ifc.isFrightened && guard < 60) begin
            cyc(); guard++;
            ifc.pelletEaten = 1'b0;
            checks++;
            if (d_vec !== e_vec) begin errors++; $display("FAIL extend_model: got %b want %b", d_vec, e_vec); end
            if (ifc.reverseDir) revs++;
            if (ifc.isFrightened && ifc.frameTick) begin
                tk++;
                if (ext) tk2++;
                if (tk == 3 && !ext) begin ifc.pelletEaten = 1'b1; ext = 1; end
            end
        end
        checks++;
        if (tk2 != FF) begin errors++; $display("FAIL extend_len: got %0d ticks want %0d", tk2, FF); end
        checks++;
        if (revs != 0) begin errors++; $display("FAIL extend_reverse: got %0d want 0", revs); end
    endtask

    task automatic test_died();
        int tk = 0, guard = 0, saved_ph, rem;
        bit seen_mode = 0;
        for (int i = 0; i < 10 && !ifc.frameTick; i++) cyc();
        cyc();
        saved_ph = m_ph;
        rem = dur[m_ph] - m_pc;
        ifc.pacmanDied = 1'b1;
        cyc();
        ifc.pacmanDied = 1'b0;
        checks++;
        if ({ifc.isScatter, ifc.isChase, ifc.isFrightened} !== 3'b000) begin
            errors++;
            $display("FAIL died_modes: got %b want 000", {ifc.isScatter, ifc.isChase, ifc.isFrightened});
        end
        while (!ifc.isScatter && !ifc.isChase && guard < 40) begin
            cyc(); guard++;
            checks++;
            if (d_vec !== e_vec) begin errors++; $display("FAIL died_model: got %b want %b", d_vec, e_vec); end
            if (ifc.isFrightened) seen_mode = 1;
            if (ifc.frameTick && !ifc.isScatter) tk++;
        end
        checks++;
        if (tk != SD || seen_mode) begin errors++; $display("FAIL died_wait: got %0d ticks want %0d", tk, SD); end
        checks++;
        if (ifc.isScatter !== 1'b1 || ifc.phaseIdx !== 3'(saved_ph)) begin
            errors++;
            $display("FAIL died_resume: scat %b phase %0d want 1 %0d", ifc.isScatter, ifc.phaseIdx, saved_ph);
        end
        tk = 0; guard = 0;
        while (!ifc.reverseDir && guard < 40) begin
            cyc(); guard++;
            if (ifc.frameTick) tk++;
        end
        checks++;
        if (tk != rem) begin errors++; $display("FAIL died_phase_cnt: got %0d ticks want %0d", tk, rem); end
    endtask

    task automatic test_same_cycle();
        int tk = 0, guard = 0;
        test_reset("same_rst");
        while (!ifc.isScatter && guard < 40) begin cyc(); guard++; end
        guard = 0;
        while (tk < 3 && guard < 40) begin
            cyc(); guard++;
            if (ifc.frameTick) tk++;
        end
        ifc.pelletEaten = 1'b1;
        cyc();
        ifc.pelletEaten = 1'b0;
        checks++;
        if ({ifc.phaseIdx, ifc.isFrightened, ifc.reverseDir, ifc.isScatter, ifc.isChase} !== {3'd1, 4'b1100}) begin
            errors++;
            $display("FAIL same_cycle_expiry: phase %0d fr %b rev %b scat %b chase %b want 1 1 1 0 0",
                     ifc.phaseIdx, ifc.isFrightened, ifc.reverseDir, ifc.isScatter, ifc.isChase);
        end
        cyc();
        checks++;
        if (ifc.reverseDir !== 1'b0) begin errors++; $display("FAIL same_cycle_single_rev: got %b want 0", ifc.reverseDir); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            ifc.pelletEaten = ($urandom_range(0, 24) == 0);
            ifc.pacmanDied  = ($urandom_range(0, 149) == 0);
            cyc();
            checks++;
            if (d_vec !== e_vec) begin
                errors++;
                $display("FAIL random_model: cycle %0d got %b want %b", i, d_vec, e_vec);
            end
        end
        ifc.pelletEaten = 1'b0;
        ifc.pacmanDied  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifc.pelletEaten = 1'b0;
        ifc.pacmanDied  = 1'b0;
        @(negedge clk);
        test_reset("reset");
        test_startup();
        test_schedule();
        test_fright();
        test_fright_extend();
        test_died();
        test_same_cycle();
        test_random();
        test_reset("mid_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghost_mode_ctrl.md
# ghost_mode_ctrl

Global ghost behaviour sequencer. Generates the 60 Hz frame tick and runs the level's scatter/chase phase schedule after the spawn delay. Overrides both phases with frightened mode on power-pellet events. Drives `isChase`/`isScatter` into every ghost movement block and gives them a one-cycle direction-reversal strobe on mode changes.

## Interface
- `TICK_DIV`, 416_667: clk cycles per frame tick (25 MHz / 60); must be ≥ 2.
- `START_DELAY_FRAMES`, 300: frames in WAIT before the schedule starts (5 s); must be ≥ 1.
- `SCAT1`, `CHASE1`, `SCAT2`, `CHASE2`, `SCAT3`, `CHASE3`, `SCAT4`: 420, 1200, 420, 1200, 300, 1200, 300. Phase 0..6 durations in frames; each must be in 1..4095.
- `FRIGHT_FRAMES`, 360: frightened duration in frames; 0 disables frightened mode.
- `FLASH_FRAMES`, 120: length of the flashing window at the end of frightened; must be ≤ `FRIGHT_FRAMES`.
- `clk` in 1: system clock, 25 MHz.
- `reset` in 1: synchronous reset, active-high.
- `pelletEaten` in 1: one-cycle pulse when Pac-Man eats a power pellet.
- `pacmanDied` in 1: one-cycle pulse when a life is lost.
- `frameTick` out 1: one-cycle pulse, once every `TICK_DIV` cycles.
- `isScatter` out 1: ghosts target their corners.
- `isChase` out 1: ghosts use their chase targets.
- `isFrightened` out 1: frightened mode is active.
- `frightFlash` out 1: frightened mode is in its last `FLASH_FRAMES` frames.
- `reverseDir` out 1: one-cycle strobe; ghosts reverse direction.
- `phaseIdx` out 3: current schedule phase, 0..7.

## Operation
- Tick generator: counter 0..`TICK_DIV`-1 that runs in every state. When the counter equals `TICK_DIV`-1 it wraps to 0, and `frameTick` is 1 on the following cycle.
- All internal updates below happen only on cycles where the registered `frameTick`=1, except pulse inputs, which act immediately.
- States: WAIT, RUN, FRIGHT.
- Counters: `delayCnt` 9 b, `phaseCnt` 12 b, `frightCnt` 9 b.
- WAIT:
  - `delayCnt` increments per tick.
  - On the tick where `delayCnt`==`START_DELAY_FRAMES`-1, go to RUN and clear `delayCnt`. No reverse strobe.
  - `pelletEaten` is ignored.
- RUN, phase < 7:
  - `phaseCnt` increments per tick.
  - On the tick where `phaseCnt`==duration(phase)-1: `phaseIdx`+1, `phaseCnt`←0, `reverseDir` pulse.
  - Phase 7 is permanent chase and never advances.
- RUN, `pelletEaten` with `FRIGHT_FRAMES`>0: go to FRIGHT, `frightCnt`←0, `reverseDir` pulse.
- FRIGHT:
  - Phase timer frozen; `phaseIdx` and `phaseCnt` held.
  - `frightCnt` increments per tick.
  - On the tick where `frightCnt`==`FRIGHT_FRAMES`-1, return to RUN with no reverse strobe.
  - `pelletEaten` restarts `frightCnt` at 0 with no reverse strobe.
- `pacmanDied` in any state: go to WAIT, clear `delayCnt` and `frightCnt`. `phaseIdx` and `phaseCnt` are preserved.
- Outputs, all registered:
  - `isScatter` = RUN and `phaseIdx` even and < 7.
  - `isChase` = RUN and (`phaseIdx` odd or == 7).
  - `isFrightened` = FRIGHT.
  - `frightFlash` = FRIGHT and `frightCnt` ≥ `FRIGHT_FRAMES`-`FLASH_FRAMES`.
  - In WAIT, `isScatter`, `isChase` and `isFrightened` are all 0.
  - At most one of `isScatter`/`isChase`/`isFrightened` is 1.
- Priority within one cycle: `reset` > `pacmanDied` > `pelletEaten` > tick-driven expiry.
- Phase expiry and `pelletEaten` in the same RUN cycle: the phase still advances and the state goes to FRIGHT. Exactly one `reverseDir` pulse.
- Fright expiry and `pelletEaten` in the same cycle: stay in FRIGHT with `frightCnt`←0.

## Timing
- Reset: state WAIT, all counters 0, `phaseIdx`=0, all outputs 0.
- First `frameTick` occurs `TICK_DIV` cycles after the first non-reset cycle.
- Mode outputs and `reverseDir` change on the clock edge that samples the triggering tick or pulse. Outputs are visible 1 cycle after the trigger.
- `reverseDir` is asserted in the same cycle the new mode outputs first appear.
- Pulse inputs held high for more than 1 cycle are treated as repeated events, each acted on per cycle.
- A `reset` asserted mid-operation takes effect on the next edge and overrides all other inputs.

## Test plan
Small parameters for all scenarios: `TICK_DIV`=4, `START_DELAY_FRAMES`=2, `SCAT1`..`SCAT4`=3, `CHASE1`..`CHASE3`=5, `FRIGHT_FRAMES`=4, `FLASH_FRAMES`=2.
- Reset release, 8 ticks:
  - `frameTick` pulses every 4 cycles.
  - All mode outputs are 0 for 2 ticks, then `isScatter`=1 with `phaseIdx`=0 and no `reverseDir`.
- Free run through the full schedule:
  - `phaseIdx` sequence 0→1 after 3 ticks, →2 after 5 more, and so on up to 7.
  - One `reverseDir` per transition, 7 in total.
  - `isChase` stays 1 indefinitely at phase 7.
- `pelletEaten` at `phaseIdx`=1, `phaseCnt`=2:
  - `isFrightened`=1 plus `reverseDir`.
  - `frightFlash`=1 from the 3rd fright tick.
  - Back to `isChase` after 4 ticks, with phase 1 resuming at `phaseCnt`=2.
- Second `pelletEaten` during fright tick 3: fright extends 4 ticks from that point, no extra `reverseDir`.
- `pacmanDied` during phase 2: all mode outputs 0 for 2 ticks, then `isScatter` with `phaseIdx`=2 and `phaseCnt` preserved.
- Same-cycle cases:
  - `pelletEaten` and phase-0 expiry together: `phaseIdx`=1, `isFrightened`=1, single `reverseDir`.
  - `reset` together with `pelletEaten`: all outputs 0.
